// File: rtl/fle_cfg_pkg.sv
// rtl/fle_cfg_pkg.sv - shared FSM states and default geometry/timing for the FLE bank programmer
package fle_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_DONE      = 3'd5
  } fle_state_e;

  localparam int DEF_NUM_CELLS = 66;
  localparam int DEF_WORD_W    = 6;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/fle_cfg_phase_timer.sv
// rtl/fle_cfg_phase_timer.sv - loadable down-counter timing the SETUP/PULSE/HOLD phases
module fle_cfg_phase_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_cnt;

  // A phase of N cycles is loaded with N-1 so that o_zero marks its final cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fle_bank_programmer.sv
// rtl/fle_bank_programmer.sv - streams configuration beats into FLE cells via bl/wl write pulses
module fle_bank_programmer
  import fle_cfg_pkg::*;
#(
  parameter int NUM_CELLS = DEF_NUM_CELLS,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [WORD_W-1:0]    cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [0:NUM_CELLS-1] bl,
  output logic [0:NUM_CELLS-1] wl,
  output logic                 cfg_busy,
  output logic                 cfg_done
);

  localparam int NBEATS = ceil_div(NUM_CELLS, WORD_W);
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int TMR_W  = 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  fle_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [0:NUM_CELLS-1] r_bl, r_wl, w_bl_nxt, w_wl_nxt, w_tgt, w_place;
  logic                 w_tmr_load, w_tmr_zero;
  logic [TMR_W-1:0]     w_tmr_val;

  fle_cfg_phase_timer #(.TMR_W(TMR_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .o_zero    (w_tmr_zero)
  );

  // Cells owned by the current beat, and the incoming beat spread onto them.
  always_comb begin
    w_tgt   = '0;
    w_place = '0;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (CNT_W'(c / WORD_W) == r_cnt) begin
        w_tgt[c]   = 1'b1;
        w_place[c] = cfg_data[c % WORD_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bl_nxt    = r_bl;
    w_wl_nxt    = '0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      ST_IDLE: begin
        w_bl_nxt = '0;
        if (cfg_start && !cfg_abort) begin
          w_state_nxt = ST_WAIT_DATA;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_DATA: begin
        w_bl_nxt = '0;
        if (cfg_valid) begin
          w_state_nxt = ST_SETUP;
          w_bl_nxt    = w_place;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_PULSE;
          w_wl_nxt    = w_tgt;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(PULSE_CYC - 1);
        end
      end
      ST_PULSE: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_HOLD;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(HOLD_CYC - 1);
        end else begin
          w_wl_nxt = w_tgt;
        end
      end
      ST_HOLD: begin
        if (w_tmr_zero) begin
          w_bl_nxt = '0;
          if (r_cnt < LAST_BEAT) begin
            w_state_nxt = ST_WAIT_DATA;
            w_cnt_nxt   = r_cnt + 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_bl_nxt    = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bl_nxt    = '0;
      end
    endcase
    // Abort overrides every busy-state decision, including the DONE pulse.
    if (r_state != ST_IDLE && cfg_abort) begin
      w_state_nxt = ST_IDLE;
      w_bl_nxt    = '0;
      w_wl_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bl    <= '0;
      r_wl    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bl    <= w_bl_nxt;
      r_wl    <= w_wl_nxt;
    end
  end

  assign bl        = r_bl;
  assign wl        = r_wl;
  assign cfg_ready = (r_state == ST_WAIT_DATA);
  assign cfg_busy  = (r_state != ST_IDLE);
  assign cfg_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_fle_bank_programmer.sv
// tb/tb_fle_bank_programmer.sv - randomized self-checking bench for fle_bank_programmer
module tb_fle_bank_programmer;

  localparam int NC = 66;
  localparam int WW = 6;
  localparam int NB = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_ready, cfg_busy, cfg_done;
  logic [0:NC-1] bl, wl;

  int checks = 0;
  int fails = 0;
  int cycle_no = 0;
  int hs_first = -1;
  int done_cnt = 0;
  int done_cycle = -1;
  int tgt_viol = 0;
  int gap_viol = 0;
  logic [WW-1:0] beats_q[$];
  logic          prog[NC];
  int            pulses[NC];

  fle_bank_programmer dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_start(cfg_start),
    .cfg_abort(cfg_abort),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .bl       (bl),
    .wl       (wl),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  task automatic clear_model();
    beats_q.delete();
    hs_first = -1; done_cnt = 0; done_cycle = -1; tgt_viol = 0; gap_viol = 0;
    for (int i = 0; i < NC; i++) begin
      prog[i] = 1'b0;
      pulses[i] = 0;
    end
  endtask

  // Advance one clock and record what the cell array sees.
  task automatic cyc();
    int cur;
    int n;
    if (reset && cfg_ready && cfg_valid && !cfg_abort) begin
      beats_q.push_back(cfg_data);
      if (hs_first < 0) hs_first = cycle_no;
    end
    @(posedge clk);
    #1;
    cycle_no++;
    cur = beats_q.size() - 1;
    n = 0;
    for (int i = 0; i < NC; i++) begin
      if (wl[i]) begin
        n++;
        prog[i] = bl[i];
        pulses[i]++;
        if (cur < 0 || (i / WW) != cur) tgt_viol++;
      end
      if (bl[i] && (cur < 0 || (i / WW) != cur)) tgt_viol++;
    end
    if (n > WW) tgt_viol++;
    if (cfg_done) begin
      done_cnt++;
      done_cycle = cycle_no;
    end
  endtask

  function automatic int model_mismatches();
    int n = 0;
    logic [WW-1:0] b;
    if (beats_q.size() != NB) return 1000;
    for (int i = 0; i < NC; i++) begin
      b = beats_q[i / WW];
      if (prog[i] !== b[i % WW]) n++;
      if (pulses[i] != 2) n++;
    end
    return n;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!cfg_ready && t < 100) begin
      cyc();
      t++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_timeout: cfg_ready=%b want 1", cfg_ready);
    end
  endtask

  task automatic do_pass(input int gap, input logic use_fixed, input logic [WW-1:0] fixed_pat,
                         input logic last_ones, input int abort_beat, input int start_beat);
    int t;
    clear_model();
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      wait_ready();
      cfg_data = use_fixed ? fixed_pat : WW'($urandom);
      if (last_ones && k == NB - 1) cfg_data = '1;
      cfg_valid = 1'b1;
      cfg_start = (k == start_beat);
      cyc();
      cfg_start = 1'b0;
      if (k == abort_beat) begin
        t = 0;
        while (wl == '0 && t < 20) begin
          cyc();
          t++;
        end
        cfg_abort = 1'b1;
        cfg_valid = 1'b0;
        cyc();
        cfg_abort = 1'b0;
        return;
      end
      if (gap > 0 && k < NB - 1) begin
        cfg_valid = 1'b0;
        wait_ready();
        repeat (gap) begin
          cyc();
          if (!(cfg_ready === 1'b1 && bl == '0 && wl == '0)) gap_viol++;
        end
      end
    end
    cfg_valid = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 40) begin
      cyc();
      t++;
    end
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    checks++; if (bl !== '0)        begin fails++; $display("FAIL reset_bl: got %h want 0", bl); end
    checks++; if (wl !== '0)        begin fails++; $display("FAIL reset_wl: got %h want 0", wl); end
    checks++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", cfg_ready); end
    checks++; if (cfg_busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
    checks++; if (cfg_done !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    reset = 1'b1;
    repeat (2) cyc();
    checks++; if (cfg_busy !== 1'b0)  begin fails++; $display("FAIL post_reset_busy: got %b want 0", cfg_busy); end
  endtask

  task automatic test_full_pass();
    int bad = 0;
    do_pass(0, 1'b1, 6'b101010, 1'b0, -1, -1);
    for (int i = 0; i < NC; i++) if (prog[i] !== 1'(i % 2)) bad++;
    checks++; if (bad != 0)       begin fails++; $display("FAIL full_alt_cells: %0d bad cells want 0", bad); end
    checks++; if (model_mismatches() != 0) begin fails++; $display("FAIL full_model: %0d mismatches want 0", model_mismatches()); end
    checks++; if (done_cnt != 1)  begin fails++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_cycle - hs_first != 55) begin fails++; $display("FAIL full_done_latency: got %0d want 55", done_cycle - hs_first); end
    checks++; if (tgt_viol != 0)  begin fails++; $display("FAIL full_target: %0d violations want 0", tgt_viol); end
    checks++; if (cfg_busy !== 1'b0) begin fails++; $display("FAIL full_idle_after: busy=%b want 0", cfg_busy); end
  endtask

  task automatic test_last_beat();
    int bad = 0;
    do_pass(0, 1'b0, '0, 1'b1, -1, -1);
    for (int i = 60; i < NC; i++) if (prog[i] !== 1'b1) bad++;
    checks++; if (bad != 0)      begin fails++; $display("FAIL last_beat_cells: %0d bad want 0", bad); end
    checks++; if (tgt_viol != 0) begin fails++; $display("FAIL last_beat_target: %0d violations want 0", tgt_viol); end
    checks++; if (model_mismatches() != 0) begin fails++; $display("FAIL last_beat_model: %0d mismatches want 0", model_mismatches()); end
  endtask

  task automatic test_random_passes();
    for (int p = 0; p < 3; p++) begin
      do_pass(int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, -1, -1);
      checks++; if (model_mismatches() != 0) begin fails++; $display("FAIL rand_model[%0d]: %0d mismatches want 0", p, model_mismatches()); end
      checks++; if (done_cnt != 1)  begin fails++; $display("FAIL rand_done[%0d]: got %0d want 1", p, done_cnt); end
      checks++; if (tgt_viol != 0)  begin fails++; $display("FAIL rand_target[%0d]: %0d want 0", p, tgt_viol); end
    end
  endtask

  task automatic test_gaps();
    do_pass(10, 1'b0, '0, 1'b0, -1, -1);
    checks++; if (gap_viol != 0) begin fails++; $display("FAIL gap_wait_state: %0d violations want 0", gap_viol); end
    checks++; if (model_mismatches() != 0) begin fails++; $display("FAIL gap_model: %0d mismatches want 0", model_mismatches()); end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL gap_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    do_pass(0, 1'b0, '0, 1'b0, 4, -1);
    checks++; if (wl !== '0)        begin fails++; $display("FAIL abort_wl: got %h want 0", wl); end
    checks++; if (bl !== '0)        begin fails++; $display("FAIL abort_bl: got %h want 0", bl); end
    checks++; if (cfg_busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", cfg_busy); end
    repeat (10) cyc();
    checks++; if (done_cnt != 0)    begin fails++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    do_pass(0, 1'b0, '0, 1'b0, -1, -1);
    checks++; if (model_mismatches() != 0) begin fails++; $display("FAIL abort_restart_model: %0d mismatches want 0", model_mismatches()); end
    checks++; if (tgt_viol != 0)    begin fails++; $display("FAIL abort_restart_target: %0d want 0", tgt_viol); end
  endtask

  task automatic test_reset_mid_pulse();
    int t = 0;
    clear_model();
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    wait_ready();
    cfg_data = WW'($urandom);
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    while (wl == '0 && t < 20) begin
      cyc();
      t++;
    end
    checks++; if (wl == '0) begin fails++; $display("FAIL rst_pulse_seen: wl=%h want nonzero", wl); end
    #2 reset = 1'b0;
    #1;
    checks++; if (wl !== '0) begin fails++; $display("FAIL rst_async_wl: got %h want 0", wl); end
    checks++; if (bl !== '0) begin fails++; $display("FAIL rst_async_bl: got %h want 0", bl); end
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    checks++; if (cfg_busy !== 1'b0) begin fails++; $display("FAIL rst_release_busy: got %b want 0", cfg_busy); end
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_restart_ready: got %b want 1", cfg_ready); end
    cfg_abort = 1'b1;
    cyc();
    cfg_abort = 1'b0;
    checks++; if (cfg_busy !== 1'b0) begin fails++; $display("FAIL rst_cleanup_busy: got %b want 0", cfg_busy); end
  endtask

  task automatic test_start_abort();
    do_pass(0, 1'b0, '0, 1'b0, -1, 3);
    checks++; if (model_mismatches() != 0) begin fails++; $display("FAIL busy_start_model: %0d mismatches want 0", model_mismatches()); end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL busy_start_done: got %0d want 1", done_cnt); end
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    cyc();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    checks++; if (cfg_busy !== 1'b0)  begin fails++; $display("FAIL start_abort_busy: got %b want 0", cfg_busy); end
    checks++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL start_abort_ready: got %b want 0", cfg_ready); end
    cfg_abort = 1'b1;
    cyc();
    cfg_abort = 1'b0;
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL idle_abort_noeffect: ready=%b want 1", cfg_ready); end
    cfg_abort = 1'b1;
    cyc();
    cfg_abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_last_beat();
    test_random_passes();
    test_gaps();
    test_abort();
    test_reset_mid_pulse();
    test_start_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
